// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: state register with bounded memory-wait
// supervision, sticky error flags and state-decoded datapath controls.
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic [2:0] ALUOp,
    output logic [3:0] State,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_error
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_I_EXEC    = 4'd9,
        S_I_WB      = 4'd10,
        S_JUMP      = 4'd11,
        S_HALT      = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam int                CNT_W     = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_wait;
    logic             r_illegal;
    logic             r_mem_err;
    logic             w_waiting;
    logic             w_timeout;
    logic             w_illegal;

    // The counter holds the number of mem_ready-low cycles already spent in
    // the current access, so a low in the cycle it equals MEM_TIMEOUT aborts.
    assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEM_READ) || (r_state == S_MEM_WRITE);
    assign w_timeout = (MEM_TIMEOUT != 0) && w_waiting && !mem_ready && (r_wait == TIMEOUT_C);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_next    = r_state;
        w_illegal = 1'b0;
        case (r_state)
            S_FETCH:     if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE:                          w_next = S_R_EXEC;
                    OP_LW, OP_SW:                      w_next = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                    w_next = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:  w_next = S_I_EXEC;
                    OP_J, OP_JAL:                      w_next = S_JUMP;
                    default: begin
                        w_next    = S_HALT;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR:  w_next = (Opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (mem_ready) w_next = S_MEM_WB;
            S_MEM_WRITE: if (mem_ready) w_next = S_FETCH;
            S_R_EXEC:    w_next = S_R_WB;
            S_I_EXEC:    w_next = S_I_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_I_WB, S_JUMP: w_next = S_FETCH;
            S_HALT:      w_next = S_HALT;
            default:     w_next = S_HALT;
        endcase
        if (w_timeout) w_next = S_HALT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_wait    <= '0;
            r_illegal <= 1'b0;
            r_mem_err <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state <= w_next;
            if (w_next != r_state)
                r_wait <= '0;
            else if (w_waiting && !mem_ready)
                r_wait <= r_wait + CNT_W'(1);
            if (w_illegal) r_illegal <= 1'b1;
            if (w_timeout) r_mem_err <= 1'b1;
        end
    end

    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IorD       = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSource   = 2'b00;
        RegDst     = 2'b00;
        MemtoReg   = 2'b00;
        ALUOp      = 3'b000;
        instr_done = 1'b0;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE:    ALUSrcB = 2'b11;
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 2'b01;
                instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 3'b111;
            end
            S_R_WB: begin
                RegWrite   = 1'b1;
                RegDst     = 2'b01;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 3'b001;
                PCSource   = 2'b01;
                PCWrite    = ((Opcode == OP_BEQ) && Zero) || ((Opcode == OP_BNE) && !Zero);
                instr_done = 1'b1;
            end
            S_I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (Opcode)
                    OP_ANDI: ALUOp = 3'b011;
                    OP_ORI:  ALUOp = 3'b010;
                    OP_LUI:  ALUOp = 3'b100;
                    default: ALUOp = 3'b000;
                endcase
            end
            S_I_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
                if (Opcode == OP_JAL) begin
                    RegWrite = 1'b1;
                    RegDst   = 2'b10;
                    MemtoReg = 2'b10;
                end
            end
            default: ;
        endcase
    end

    assign State      = r_state;
    assign illegal_op = r_illegal;
    assign mem_error  = r_mem_err;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table for every
// instruction class, plus hand sequences for HALT, reset and memory timeouts.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] Opcode = 6'h00;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource, RegDst, MemtoReg;
    logic [2:0] ALUOp;
    logic [3:0] State;
    logic       instr_done, illegal_op, mem_error;

    multicycle_control #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .IorD(IorD), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUOp(ALUOp),
        .State(State), .instr_done(instr_done), .illegal_op(illegal_op), .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    // Control bundle: {PCWrite,IRWrite,MemRead,MemWrite,IorD,RegWrite,ALUSrcA,
    //                  ALUSrcB,PCSource,RegDst,MemtoReg,ALUOp,instr_done}
    logic [18:0] w_ctl;
    assign w_ctl = {PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, ALUSrcA,
                    ALUSrcB, PCSource, RegDst, MemtoReg, ALUOp, instr_done};

    typedef struct {
        logic [5:0]  op;
        logic        zero;
        logic        rdy;
        logic [3:0]  st;
        logic [18:0] ctl;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic logic [18:0] mk(input logic pcw, input logic irw, input logic mr,
                                       input logic mw, input logic iord, input logic rw,
                                       input logic asa, input logic [1:0] asb,
                                       input logic [1:0] pcs, input logic [1:0] rd,
                                       input logic [1:0] m2r, input logic [2:0] aop,
                                       input logic done);
        return {pcw, irw, mr, mw, iord, rw, asa, asb, pcs, rd, m2r, aop, done};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [5:0] op, input logic z, input logic rdy,
                        input logic [3:0] st, input logic [18:0] ctl);
        vec_t v;
        v.op = op; v.zero = z; v.rdy = rdy; v.st = st; v.ctl = ctl;
        vecs.push_back(v);
    endtask

    task automatic apply(input logic [5:0] op, input logic z, input logic rdy);
        Opcode = op; Zero = z; mem_ready = rdy;
        #1;
    endtask

    // Asserts reset mid-cycle, checks its immediate effect, releases on a falling edge.
    task automatic hard_reset(input string tag);
        reset = 1'b1;
        #1;
        check({tag, " rst state"}, 32'(State), 32'd0);
        check({tag, " rst illegal_op"}, 32'(illegal_op), 32'd0);
        check({tag, " rst mem_error"}, 32'(mem_error), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [18:0] F1, F0, DEC, MA, MRD, MWB, MWR0, MWR1, REX, RWB, BR1, BR0, IWB, JMP, JAL;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        F1   = mk(1,1,1,0,0,0,0,2'b01,2'b00,2'b00,2'b00,3'b000,0);
        F0   = mk(0,0,1,0,0,0,0,2'b01,2'b00,2'b00,2'b00,3'b000,0);
        DEC  = mk(0,0,0,0,0,0,0,2'b11,2'b00,2'b00,2'b00,3'b000,0);
        MA   = mk(0,0,0,0,0,0,1,2'b10,2'b00,2'b00,2'b00,3'b000,0);
        MRD  = mk(0,0,1,0,1,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0);
        MWB  = mk(0,0,0,0,0,1,0,2'b00,2'b00,2'b00,2'b01,3'b000,1);
        MWR0 = mk(0,0,0,1,1,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0);
        MWR1 = mk(0,0,0,1,1,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1);
        REX  = mk(0,0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b111,0);
        RWB  = mk(0,0,0,0,0,1,0,2'b00,2'b00,2'b01,2'b00,3'b000,1);
        BR1  = mk(1,0,0,0,0,0,1,2'b00,2'b01,2'b00,2'b00,3'b001,1);
        BR0  = mk(0,0,0,0,0,0,1,2'b00,2'b01,2'b00,2'b00,3'b001,1);
        IWB  = mk(0,0,0,0,0,1,0,2'b00,2'b00,2'b00,2'b00,3'b000,1);
        JMP  = mk(1,0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b000,1);
        JAL  = mk(1,0,0,0,0,1,0,2'b00,2'b10,2'b10,2'b10,3'b000,1);

        // add
        push(6'h00,0,1,0,F1); push(6'h00,0,1,1,DEC); push(6'h00,0,1,6,REX); push(6'h00,0,1,7,RWB);
        // lw: one fetch stall, then three MEM_READ stalls
        push(6'h23,0,0,0,F0); push(6'h23,0,1,0,F1); push(6'h23,0,1,1,DEC); push(6'h23,0,1,2,MA);
        push(6'h23,0,0,3,MRD); push(6'h23,0,0,3,MRD); push(6'h23,0,0,3,MRD);
        push(6'h23,0,1,3,MRD); push(6'h23,0,1,4,MWB);
        // sw with one write stall
        push(6'h2B,0,1,0,F1); push(6'h2B,0,1,1,DEC); push(6'h2B,0,1,2,MA);
        push(6'h2B,0,0,5,MWR0); push(6'h2B,0,1,5,MWR1);
        // beq / bne with both Zero values
        push(6'h04,1,1,0,F1); push(6'h04,1,1,1,DEC); push(6'h04,1,1,8,BR1);
        push(6'h04,0,1,0,F1); push(6'h04,0,1,1,DEC); push(6'h04,0,1,8,BR0);
        push(6'h05,1,1,0,F1); push(6'h05,1,1,1,DEC); push(6'h05,1,1,8,BR0);
        push(6'h05,0,1,0,F1); push(6'h05,0,1,1,DEC); push(6'h05,0,1,8,BR1);
        // addi / andi / ori / lui
        push(6'h08,0,1,0,F1); push(6'h08,0,1,1,DEC);
        push(6'h08,0,1,9,mk(0,0,0,0,0,0,1,2'b10,2'b00,2'b00,2'b00,3'b000,0)); push(6'h08,0,1,10,IWB);
        push(6'h0C,0,1,0,F1); push(6'h0C,0,1,1,DEC);
        push(6'h0C,0,1,9,mk(0,0,0,0,0,0,1,2'b10,2'b00,2'b00,2'b00,3'b011,0)); push(6'h0C,0,1,10,IWB);
        push(6'h0D,0,1,0,F1); push(6'h0D,0,1,1,DEC);
        push(6'h0D,0,1,9,mk(0,0,0,0,0,0,1,2'b10,2'b00,2'b00,2'b00,3'b010,0)); push(6'h0D,0,1,10,IWB);
        push(6'h0F,0,1,0,F1); push(6'h0F,0,1,1,DEC);
        push(6'h0F,0,1,9,mk(0,0,0,0,0,0,1,2'b10,2'b00,2'b00,2'b00,3'b100,0)); push(6'h0F,0,1,10,IWB);
        // j / jal
        push(6'h02,0,1,0,F1); push(6'h02,0,1,1,DEC); push(6'h02,0,1,11,JMP);
        push(6'h03,0,1,0,F1); push(6'h03,0,1,1,DEC); push(6'h03,0,1,11,JAL);

        // Power-on reset, released on a falling edge.
        @(negedge clk);
        @(negedge clk);
        check("por state", 32'(State), 32'd0);
        check("por illegal_op", 32'(illegal_op), 32'd0);
        check("por mem_error", 32'(mem_error), 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            apply(vecs[i].op, vecs[i].zero, vecs[i].rdy);
            check($sformatf("row%0d state", i), 32'(State), 32'(vecs[i].st));
            check($sformatf("row%0d ctl", i), 32'(w_ctl), 32'(vecs[i].ctl));
            @(negedge clk);
        end
        check("table illegal_op", 32'(illegal_op), 32'd0);
        check("table mem_error", 32'(mem_error), 32'd0);

        // Illegal opcode: HALT ignores everything until reset.
        apply(6'h3F,0,1); check("ill fetch", 32'(State), 32'd0); @(negedge clk);
        apply(6'h3F,0,1); check("ill decode", 32'(State), 32'd1); @(negedge clk);
        for (int c = 0; c < 20; c++) begin
            apply(6'($urandom), 1'($urandom), 1'($urandom));
            check($sformatf("halt%0d state", c), 32'(State), 32'd15);
            check($sformatf("halt%0d ctl", c), 32'(w_ctl), 32'd0);
            check($sformatf("halt%0d illegal_op", c), 32'(illegal_op), 32'd1);
            @(negedge clk);
        end
        hard_reset("ill");
        apply(6'h00,0,1);
        check("post-rst state", 32'(State), 32'd0);
        check("post-rst ctl", 32'(w_ctl), 32'(F1));

        // Fetch stuck low: 16 FETCH cycles (count 0..15), then HALT with mem_error.
        hard_reset("to1");
        for (int c = 0; c < 16; c++) begin
            apply(6'h00,0,0);
            check($sformatf("fto%0d state", c), 32'(State), 32'd0);
            check($sformatf("fto%0d ctl", c), 32'(w_ctl), 32'(F0));
            @(negedge clk);
        end
        apply(6'h00,0,0);
        check("fto halt state", 32'(State), 32'd15);
        check("fto mem_error", 32'(mem_error), 32'd1);
        check("fto illegal_op", 32'(illegal_op), 32'd0);
        check("fto halt ctl", 32'(w_ctl), 32'd0);

        // Ready arrives exactly at the timeout cycle: normal completion.
        hard_reset("to2");
        for (int c = 0; c < 15; c++) begin
            apply(6'h23,0,0);
            @(negedge clk);
        end
        apply(6'h23,0,1);
        check("edge fetch state", 32'(State), 32'd0);
        check("edge fetch ctl", 32'(w_ctl), 32'(F1));
        @(negedge clk);
        apply(6'h23,0,0);
        check("edge decode state", 32'(State), 32'd1);
        check("edge mem_error", 32'(mem_error), 32'd0);
        @(negedge clk);
        apply(6'h23,0,0);
        check("edge memaddr state", 32'(State), 32'd2);
        @(negedge clk);
        // Counter must restart at MEM_READ entry, so another 15 stalls are allowed.
        for (int c = 0; c < 15; c++) begin
            apply(6'h23,0,0);
            check($sformatf("rd%0d state", c), 32'(State), 32'd3);
            @(negedge clk);
        end
        apply(6'h23,0,1);
        check("rd edge state", 32'(State), 32'd3);
        @(negedge clk);
        apply(6'h23,0,1);
        check("rd wb state", 32'(State), 32'd4);
        check("rd wb ctl", 32'(w_ctl), 32'(MWB));
        check("rd mem_error", 32'(mem_error), 32'd0);
        @(negedge clk);

        // Store stuck low: MEM_WRITE times out into HALT.
        apply(6'h2B,0,1); check("sto fetch", 32'(State), 32'd0); @(negedge clk);
        apply(6'h2B,0,1); check("sto decode", 32'(State), 32'd1); @(negedge clk);
        apply(6'h2B,0,0); check("sto addr", 32'(State), 32'd2); @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            apply(6'h2B,0,0);
            check($sformatf("sto%0d state", c), 32'(State), 32'd5);
            @(negedge clk);
        end
        apply(6'h2B,0,1);
        check("sto halt state", 32'(State), 32'd15);
        check("sto mem_error", 32'(mem_error), 32'd1);
        check("sto halt ctl", 32'(w_ctl), 32'd0);

        hard_reset("end");
        apply(6'h00,0,0);
        check("end state", 32'(State), 32'd0);
        check("end ctl", 32'(w_ctl), 32'(F0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 15: max consecutive mem_ready-low wait cycles; 0 disables timeout.
REQ-002 The block SHALL have clk  in  1  sole clock, rising edge.
REQ-003 The block SHALL have reset  in  1  asynchronous, active-high reset.
REQ-004 The block SHALL have Opcode  in  6  instruction [31:26] from the instruction register, stable from DECODE until next FETCH.
REQ-005 The block SHALL have Zero  in  1  ALU zero flag.
REQ-006 The block SHALL have mem_ready  in  1  memory access complete this cycle.
REQ-007 The block SHALL have outputs PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, ALUSrcA, all 1 bit: standard multicycle datapath enables/selects.
REQ-008 The block SHALL have outputs ALUSrcB (2: 00 reg, 01 const 4, 10 sign-ext imm, 11 imm<<2), PCSource (2: 00 ALU, 01 ALUOut, 10 jump target), RegDst (2: 00 rt, 01 rd, 10 $31), MemtoReg (2: 00 ALUOut, 01 MDR, 10 PC).
REQ-009 The block SHALL have output ALUOp  3  000 add, 001 sub, 010 or, 011 and, 100 lui, 111 use funct.
REQ-010 The block SHALL have outputs State  4  current state code; instr_done  1  one-cycle retire pulse; illegal_op  1  sticky; mem_error  1  sticky.

Function
REQ-011 State codes SHALL be FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, BRANCH 8, I_EXEC 9, I_WB 10, JUMP 11, HALT 15.
REQ-012 Every control output not listed for a state SHALL be 0 in that state.
REQ-013 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00; IRWrite=PCWrite=mem_ready; go to DECODE only when mem_ready=1, else hold.
REQ-014 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000; next state by Opcode: 0x00 R_EXEC; 0x23/0x2B MEM_ADDR; 0x04/0x05 BRANCH; 0x08/0x0C/0x0D/0x0F I_EXEC; 0x02/0x03 JUMP; other HALT with illegal_op set.
REQ-015 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=000; next MEM_READ (0x23) or MEM_WRITE (0x2B).
REQ-016 MEM_READ: MemRead=1, IorD=1; hold until mem_ready, then MEM_WB.
REQ-017 MEM_WB: RegWrite=1, RegDst=00, MemtoReg=01; next FETCH.
REQ-018 MEM_WRITE: MemWrite=1, IorD=1; hold until mem_ready, then FETCH.
REQ-019 R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=111; next R_WB. R_WB: RegWrite=1, RegDst=01, MemtoReg=00; next FETCH.
REQ-020 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01, PCWrite=(Opcode==0x04 & Zero)|(Opcode==0x05 & ~Zero); next FETCH.
REQ-021 I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp 000 addi, 011 andi, 010 ori, 100 lui; next I_WB. I_WB: RegWrite=1, RegDst=00, MemtoReg=00; next FETCH.
REQ-022 JUMP: PCWrite=1, PCSource=10; for 0x03 also RegWrite=1, RegDst=10, MemtoReg=10; next FETCH.
REQ-023 instr_done SHALL be 1 combinationally in the final cycle of each instruction: MEM_WB, R_WB, BRANCH, I_WB, JUMP, and MEM_WRITE when mem_ready=1.
REQ-024 A wait counter SHALL clear on entering FETCH, MEM_READ or MEM_WRITE and increment each cycle mem_ready=0 there; when MEM_TIMEOUT!=0 and count reaches MEM_TIMEOUT with mem_ready=0, next state SHALL be HALT and mem_error set.
REQ-025 mem_ready=1 in the same cycle the timeout is reached SHALL complete the access normally; no error.
REQ-026 HALT SHALL assert no controls and be left only by reset; mem_ready and Opcode are ignored there.

Reset
REQ-027 Reset SHALL immediately force State=FETCH, wait counter=0, illegal_op=0, mem_error=0, regardless of current state or pending access.
REQ-028 In the first cycle after reset deassertion outputs SHALL be the FETCH values of REQ-013.

Verification
REQ-029 add (0x00), mem_ready=1 always -> states 0,1,6,7,0; RegWrite=1 RegDst=01 only in state 7; instr_done once.
REQ-030 lw (0x23), mem_ready low 3 cycles in MEM_READ -> state 3 held 4 cycles, then 4 with MemtoReg=01, RegWrite=1.
REQ-031 beq with Zero=1 -> PCWrite=1 PCSource=01 in state 8; bne with Zero=1 -> PCWrite=0.
REQ-032 jal (0x03) -> state 11: PCWrite=1, RegWrite=1, RegDst=10, MemtoReg=10.
REQ-033 Opcode 0x3F -> HALT, illegal_op=1, all controls 0 for 20 cycles; reset -> FETCH, flag 0.
REQ-034 MEM_TIMEOUT=15, mem_ready stuck 0 in FETCH -> HALT after 15 wait cycles, mem_error=1; repeat with mem_ready=1 at cycle 15 -> DECODE, no error.
